// File: rtl/bus_split_arbiter.sv
// Two-initiator round-robin bus arbiter with split-transaction parking and return,
// plus a hold watchdog that force-releases any grant held for HOLD_LIMIT cycles.
module bus_split_arbiter #(
  parameter logic [15:0] HOLD_LIMIT = 16'd0
) (
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  input  logic split_ack,
  input  logic split_req,
  output logic grant0,
  output logic grant1,
  output logic split_grant,
  output logic bus_busy,
  output logic split_pending,
  output logic split_owner,
  output logic timeout_err
);

  typedef enum logic [1:0] {StIdle, StBusy, StSplitRet} state_e;

  state_e      state;
  logic        cur;
  logic        last;
  logic        pend;
  logic        owner;
  logic [15:0] cnt;

  logic elig0;
  logic elig1;
  logic pick;
  logic req_cur;
  logic expire;

  // The parked initiator may not compete while its split is outstanding.
  always_comb begin
    elig0   = req0 & ~(pend & ~owner);
    elig1   = req1 & ~(pend & owner);
    pick    = (elig0 & elig1) ? ~last : elig1;
    req_cur = cur ? req1 : req0;
    expire  = (HOLD_LIMIT != 16'd0) && (cnt == HOLD_LIMIT - 16'd1);
  end

  assign split_pending = pend;
  assign split_owner   = owner;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= StIdle;
      cur         <= 1'b0;
      last        <= 1'b1;
      pend        <= 1'b0;
      owner       <= 1'b0;
      cnt         <= 16'd0;
      grant0      <= 1'b0;
      grant1      <= 1'b0;
      split_grant <= 1'b0;
      bus_busy    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        StIdle: begin
          if (pend && split_req) begin
            state       <= StSplitRet;
            cnt         <= 16'd0;
            grant0      <= ~owner;
            grant1      <= owner;
            split_grant <= 1'b1;
            bus_busy    <= 1'b1;
          end else if (elig0 || elig1) begin
            state    <= StBusy;
            cur      <= pick;
            last     <= pick;
            cnt      <= 16'd0;
            grant0   <= ~pick;
            grant1   <= pick;
            bus_busy <= 1'b1;
          end
        end
        StBusy: begin
          // Release priority: split, then request drop, then watchdog.
          if ((split_ack && !pend) || !req_cur || expire) begin
            state    <= StIdle;
            grant0   <= 1'b0;
            grant1   <= 1'b0;
            bus_busy <= 1'b0;
            if (split_ack && !pend) begin
              pend  <= 1'b1;
              owner <= cur;
            end else if (req_cur) begin
              timeout_err <= 1'b1;
            end
          end else if (cnt != 16'hFFFF) begin
            cnt <= cnt + 16'd1;
          end
        end
        StSplitRet: begin
          if (!split_req || expire) begin
            state       <= StIdle;
            pend        <= 1'b0;
            grant0      <= 1'b0;
            grant1      <= 1'b0;
            split_grant <= 1'b0;
            bus_busy    <= 1'b0;
            timeout_err <= split_req;
          end else if (cnt != 16'hFFFF) begin
            cnt <= cnt + 16'd1;
          end
        end
        default: begin
          state       <= StIdle;
          grant0      <= 1'b0;
          grant1      <= 1'b0;
          split_grant <= 1'b0;
          bus_busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_split_arbiter.sv
// Scoreboard bench: two arbiters (watchdog 5 and disabled) share random/directed stimulus;
// a transaction-level model predicts each cycle's outputs, a monitor pops and compares.
module tb_bus_split_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req0 = 1'b0, req1 = 1'b0, split_ack = 1'b0, split_req = 1'b0;

  logic g0_a, g1_a, sg_a, bb_a, sp_a, so_a, te_a;
  logic g0_b, g1_b, sg_b, bb_b, sp_b, so_b, te_b;

  always #5 clk = ~clk;

  bus_split_arbiter #(.HOLD_LIMIT(16'd5)) dut_lim5 (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .split_ack(split_ack),
    .split_req(split_req), .grant0(g0_a), .grant1(g1_a), .split_grant(sg_a),
    .bus_busy(bb_a), .split_pending(sp_a), .split_owner(so_a), .timeout_err(te_a)
  );

  bus_split_arbiter #(.HOLD_LIMIT(16'd0)) dut_lim0 (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .split_ack(split_ack),
    .split_req(split_req), .grant0(g0_b), .grant1(g1_b), .split_grant(sg_b),
    .bus_busy(bb_b), .split_pending(sp_b), .split_owner(so_b), .timeout_err(te_b)
  );

  int vectors = 0;
  int miscompares = 0;

  // Model: holder is -1 (bus free), 0/1 (initiator transaction) or 2 (split return).
  int holder[2];
  int park[2];
  int last_g[2];
  int held[2];
  bit split_out[2];
  bit tout[2];
  int limit[2];

  logic [6:0] q_exp[2][$];

  function automatic void model_reset(input int k);
    holder[k] = -1; park[k] = 0; last_g[k] = 1; held[k] = 0;
    split_out[k] = 1'b0; tout[k] = 1'b0;
  endfunction

  function automatic void model_step(input int k, input bit r, input bit a, input bit b,
                                     input bit sa, input bit sr);
    bit hit;
    bit w0, w1;
    bit rq;
    if (r) begin
      model_reset(k);
      return;
    end
    tout[k] = 1'b0;
    hit = (limit[k] != 0) && (held[k] == limit[k]);
    if (holder[k] == -1) begin
      w0 = a && !(split_out[k] && park[k] == 0);
      w1 = b && !(split_out[k] && park[k] == 1);
      if (split_out[k] && sr) begin
        holder[k] = 2; held[k] = 1;
      end else if (w0 || w1) begin
        holder[k] = (w0 && w1) ? 1 - last_g[k] : (w1 ? 1 : 0);
        last_g[k] = holder[k];
        held[k] = 1;
      end
    end else if (holder[k] == 2) begin
      if (!sr) begin
        split_out[k] = 1'b0; holder[k] = -1;
      end else if (hit) begin
        split_out[k] = 1'b0; tout[k] = 1'b1; holder[k] = -1;
      end else begin
        held[k]++;
      end
    end else begin
      rq = (holder[k] == 1) ? b : a;
      if (sa && !split_out[k]) begin
        split_out[k] = 1'b1; park[k] = holder[k]; holder[k] = -1;
      end else if (!rq) begin
        holder[k] = -1;
      end else if (hit) begin
        tout[k] = 1'b1; holder[k] = -1;
      end else begin
        held[k]++;
      end
    end
  endfunction

  function automatic logic [6:0] model_out(input int k);
    logic e0, e1, esg;
    e0  = (holder[k] == 0) || (holder[k] == 2 && park[k] == 0);
    e1  = (holder[k] == 1) || (holder[k] == 2 && park[k] == 1);
    esg = (holder[k] == 2);
    return {e0, e1, esg, (holder[k] != -1), split_out[k],
            (split_out[k] && park[k] == 1), tout[k]};
  endfunction

  function automatic logic [6:0] dut_out(input int k);
    if (k == 0) return {g0_a, g1_a, sg_a, bb_a, sp_a, so_a, te_a};
    return {g0_b, g1_b, sg_b, bb_b, sp_b, so_b, te_b};
  endfunction

  task automatic check(input string name, input logic [6:0] got, input logic [6:0] want);
    logic [6:0] m;
    m = want[2] ? 7'h7F : 7'h7D;  // owner only meaningful while a split is pending
    vectors++;
    if ((got & m) !== (want & m)) begin
      miscompares++;
      $display("FAIL %s: got g0,g1,sg,busy,sp,own,tout=%b want %b", name, got, want);
    end
  endtask

  task automatic cycle(input bit r, input bit a, input bit b, input bit sa, input bit sr);
    @(negedge clk);
    rst = r; req0 = a; req1 = b; split_ack = sa; split_req = sr;
    for (int k = 0; k < 2; k++) begin
      model_step(k, r, a, b, sa, sr);
      q_exp[k].push_back(model_out(k));
    end
  endtask

  // Reset asserted between edges must clear outputs without waiting for a clock.
  task automatic async_reset_check();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset dut_lim5", dut_out(0), 7'd0);
    check("async_reset dut_lim0", dut_out(1), 7'd0);
    for (int k = 0; k < 2; k++) begin
      model_reset(k);
      q_exp[k].delete();
      q_exp[k].push_back(model_out(k));
    end
  endtask

  initial begin : monitor
    int cyc;
    logic [6:0] e;
    cyc = 0;
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      for (int k = 0; k < 2; k++) begin
        if (q_exp[k].size() > 0) begin
          e = q_exp[k].pop_front();
          check($sformatf("%s cycle %0d", (k == 0) ? "dut_lim5" : "dut_lim0", cyc),
                dut_out(k), e);
        end
      end
    end
  end

  initial begin : stimulus
    bit a, b, sr;
    limit[0] = 5;
    limit[1] = 0;
    model_reset(0);
    model_reset(1);

    repeat (2) cycle(1, 0, 0, 0, 0);

    // Round-robin: both request; the grantee drops for one cycle after 3 grant cycles.
    for (int i = 0; i < 16; i++) begin
      a = 1'b1; b = 1'b1;
      if (holder[0] == 0 && held[0] == 3) a = 1'b0;
      if (holder[0] == 1 && held[0] == 3) b = 1'b0;
      cycle(0, a, b, 0, 0);
    end
    repeat (2) cycle(0, 0, 0, 0, 0);

    // Split on initiator 0, initiator 1 served, split return after req1 drops.
    repeat (2) cycle(0, 1, 0, 0, 0);
    cycle(0, 1, 1, 1, 0);
    repeat (3) cycle(0, 1, 1, 0, 0);
    repeat (1) cycle(0, 1, 1, 0, 1);
    repeat (3) cycle(0, 1, 0, 0, 1);
    cycle(0, 1, 0, 0, 0);
    repeat (3) cycle(0, 0, 0, 0, 0);

    // Split return wins over a simultaneous new request.
    repeat (2) cycle(0, 1, 0, 0, 0);
    cycle(0, 1, 0, 1, 0);
    repeat (3) cycle(0, 0, 1, 0, 1);
    repeat (3) cycle(0, 0, 1, 0, 0);
    repeat (2) cycle(0, 0, 0, 0, 0);

    // Watchdog: long hold; lim5 cycles through timeouts, lim0 holds throughout.
    repeat (110) cycle(0, 1, 0, 0, 0);
    repeat (2) cycle(0, 0, 0, 0, 0);

    // Split return held past the watchdog on lim5.
    repeat (2) cycle(0, 1, 0, 0, 0);
    cycle(0, 1, 0, 1, 0);
    repeat (8) cycle(0, 0, 0, 0, 1);
    repeat (2) cycle(0, 0, 0, 0, 0);

    // Reset during split return, then restart with both requesting.
    repeat (2) cycle(0, 1, 0, 0, 0);
    cycle(0, 1, 0, 1, 0);
    repeat (2) cycle(0, 0, 0, 0, 1);
    async_reset_check();
    repeat (2) cycle(1, 1, 1, 0, 1);
    repeat (4) cycle(0, 1, 1, 0, 0);

    // Randomised levels with occasional split pulses and resets.
    a = 1'b0; b = 1'b0; sr = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) a = ~a;
      if ($urandom_range(0, 7) == 0) b = ~b;
      if ($urandom_range(0, 11) == 0) sr = ~sr;
      if ($urandom_range(0, 499) == 0) begin
        async_reset_check();
        cycle(1, a, b, 0, sr);
      end else begin
        cycle(0, a, b, ($urandom_range(0, 9) == 0), sr);
      end
    end
    cycle(0, 0, 0, 0, 0);

    @(posedge clk);
    #4;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
